// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM state
// encoding and the default geometry used by the core glue.
package rf_pkg;
   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;

   typedef enum logic {
      RF_ST_IDLE  = 1'b0,
      RF_ST_CLEAR = 1'b1
   } rf_state_e;
endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the core (decode/writeback/debugger) and the register file.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 3,
   parameter int NUM_WR = 2
);
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic                     clr_req;
   logic                     clr_busy;
   logic                     clr_done;
   logic                     wr_conflict;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, clr_req,
      input  rd_data, clr_busy, clr_done, wr_conflict
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, clr_req,
      output rd_data, clr_busy, clr_done, wr_conflict
   );
endinterface

// File: rtl/rf_wr_resolve.sv
// Resolves all write ports against one query address: reports whether any
// enabled port targets it and the data of the highest-index such port.
module rf_wr_resolve #(
   parameter int NUM_WR = 2,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
   input  logic [ADDR_W-1:0]        q_addr_i,
   output logic                     hit_o,
   output logic [DATA_W-1:0]        data_o
);
   // Later iterations override earlier ones, so the highest index wins.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         if (wr_en_i[k] && (wr_addr_i[k*ADDR_W +: ADDR_W] == q_addr_i)) begin
            hit_o  = 1'b1;
            data_o = wr_data_i[k*DATA_W +: DATA_W];
         end
      end
   end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with sequential clear engine, optional hard-zero
// r0, write-through bypass and a registered same-address write conflict flag.
module regfile_mp
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = 3,
   parameter int NUM_WR   = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   regfile_mp_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   rf_state_e         state_q;
   logic [ADDR_W-1:0] clr_ptr_q;
   logic              clr_done_q;
   logic              wr_conflict_q;
   logic              wr_conflict_d;
   logic              clr_busy;
   logic [NUM_WR-1:0] wr_en_eff;
   logic [DEPTH-1:0]  ent_hit;
   logic [DATA_W-1:0] ent_data [DEPTH];

   assign clr_busy = (state_q == RF_ST_CLEAR);

   // A write is live only outside a clear and only to a writable address.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_WR; gi++) begin : g_wen
         assign wr_en_eff[gi] = bus.wr_en[gi] && !clr_busy &&
            !(ZERO_REG && (bus.wr_addr[gi*ADDR_W +: ADDR_W] == '0));
      end
   endgenerate

   always_comb begin
      wr_conflict_d = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int j = i + 1; j < NUM_WR; j++) begin
            if (wr_en_eff[i] && wr_en_eff[j] &&
                (bus.wr_addr[i*ADDR_W +: ADDR_W] == bus.wr_addr[j*ADDR_W +: ADDR_W]))
               wr_conflict_d = 1'b1;
         end
      end
   end

   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wsel
         rf_wr_resolve #(
            .NUM_WR (NUM_WR),
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
         ) u_wsel (
            .wr_en_i   (wr_en_eff),
            .wr_addr_i (bus.wr_addr),
            .wr_data_i (bus.wr_data),
            .q_addr_i  (ADDR_W'(gi)),
            .hit_o     (ent_hit[gi]),
            .data_o    (ent_data[gi])
         );
      end
   endgenerate

   // Storage carries no reset; contents are defined only by the clear engine.
   always_ff @(posedge clk) begin
      for (int e = 0; e < DEPTH; e++) begin
         if (clr_busy && (clr_ptr_q == ADDR_W'(e)))
            mem_q[e] <= '0;
         else if (ent_hit[e])
            mem_q[e] <= ent_data[e];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RF_ST_CLEAR;
         clr_ptr_q     <= '0;
         clr_done_q    <= 1'b0;
         wr_conflict_q <= 1'b0;
      end else begin
         wr_conflict_q <= wr_conflict_d;
         case (state_q)
            RF_ST_CLEAR: begin
               clr_ptr_q <= clr_ptr_q + 1'b1;
               if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                  state_q    <= RF_ST_IDLE;
                  clr_done_q <= 1'b1;
               end else begin
                  clr_done_q <= 1'b0;
               end
            end
            default: begin
               clr_done_q <= 1'b0;
               if (bus.clr_req)
                  state_q <= RF_ST_CLEAR;
            end
         endcase
      end
   end

   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] ra;
         logic              rhit;
         logic [DATA_W-1:0] rbyp;
         logic [DATA_W-1:0] rval;

         assign ra = bus.rd_addr[gi*ADDR_W +: ADDR_W];

         rf_wr_resolve #(
            .NUM_WR (NUM_WR),
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
         ) u_byp (
            .wr_en_i   (wr_en_eff),
            .wr_addr_i (bus.wr_addr),
            .wr_data_i (bus.wr_data),
            .q_addr_i  (ra),
            .hit_o     (rhit),
            .data_o    (rbyp)
         );

         always_comb begin
            if (clr_busy)
               rval = '0;
            else if (ZERO_REG && (ra == '0))
               rval = '0;
            else if (BYPASS && rhit)
               rval = rbyp;
            else
               rval = mem_q[ra];
         end

         assign bus.rd_data[gi*DATA_W +: DATA_W] = rval;
      end
   endgenerate

   assign bus.clr_busy    = clr_busy;
   assign bus.clr_done    = clr_done_q;
   assign bus.wr_conflict = wr_conflict_q;
endmodule
